// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 keyboard receiver that tracks one held key and presents it as an HID usage ID.
// Frames are sampled on synchronised PS2_CLK falling edges; a decoder follows make/break/extended prefixes.
module ps2_keycode_rx #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keycode,
  output logic [7:0] Scan_Code,
  output logic       Scan_Valid,
  output logic       Frame_Err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  typedef enum logic [1:0] {NORMAL, BRK, EXT, EXT_BRK} dec_state_t;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  // bit 0 carries PS2_CLK, bit 1 carries PS2_DAT
  logic [1:0]      meta_reg;
  logic [1:0]      sync_reg;
  logic            ps2_clk_dly_reg;

  rx_state_t       rx_state_reg, rx_state_next;
  logic [2:0]      bit_cnt_reg, bit_cnt_next;
  logic [7:0]      shift_reg, shift_next;
  logic            parity_reg, parity_next;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;

  dec_state_t      dec_state_reg, dec_state_next;
  logic [7:0]      keycode_reg, keycode_next;
  logic [7:0]      scan_code_reg, scan_code_next;
  logic            scan_valid_reg, scan_valid_next;
  logic            frame_err_reg, frame_err_next;

  logic            ps2_dat_s;
  logic            fall_edge;
  logic            accept_byte;
  logic [8:0]      map_res;

  function automatic logic [8:0] map_key(input logic [7:0] code);
    case (code)
      8'h1C:   map_key = {1'b1, 8'h04};
      8'h23:   map_key = {1'b1, 8'h07};
      8'h1B:   map_key = {1'b1, 8'h16};
      8'h1D:   map_key = {1'b1, 8'h1A};
      8'h29:   map_key = {1'b1, 8'h2C};
      8'h5A:   map_key = {1'b1, 8'h28};
      default: map_key = 9'h000;
    endcase
  endfunction

  assign ps2_dat_s = sync_reg[1];
  assign fall_edge = ps2_clk_dly_reg & ~sync_reg[0];
  assign map_res   = map_key(shift_reg);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      meta_reg        <= 2'b11;
      sync_reg        <= 2'b11;
      ps2_clk_dly_reg <= 1'b1;
      rx_state_reg    <= IDLE;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      parity_reg      <= 1'b0;
      to_cnt_reg      <= '0;
      dec_state_reg   <= NORMAL;
      keycode_reg     <= '0;
      scan_code_reg   <= '0;
      scan_valid_reg  <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      meta_reg        <= {PS2_DAT, PS2_CLK};
      sync_reg        <= meta_reg;
      ps2_clk_dly_reg <= sync_reg[0];
      rx_state_reg    <= rx_state_next;
      bit_cnt_reg     <= bit_cnt_next;
      shift_reg       <= shift_next;
      parity_reg      <= parity_next;
      to_cnt_reg      <= to_cnt_next;
      dec_state_reg   <= dec_state_next;
      keycode_reg     <= keycode_next;
      scan_code_reg   <= scan_code_next;
      scan_valid_reg  <= scan_valid_next;
      frame_err_reg   <= frame_err_next;
    end
  end

  always_comb begin
    rx_state_next   = rx_state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    parity_next     = parity_reg;
    to_cnt_next     = to_cnt_reg;
    dec_state_next  = dec_state_reg;
    keycode_next    = keycode_reg;
    scan_code_next  = scan_code_reg;
    scan_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    accept_byte     = 1'b0;

    // Saturating inactivity counter; only meaningful inside a frame
    if (rx_state_reg == IDLE || fall_edge) begin
      to_cnt_next = '0;
    end else if (to_cnt_reg != TO_MAX) begin
      to_cnt_next = to_cnt_reg + 1'b1;
    end

    case (rx_state_reg)
      IDLE: begin
        if (fall_edge && !ps2_dat_s) begin
          rx_state_next = DATA;
          bit_cnt_next  = '0;
        end
      end
      DATA: begin
        if (fall_edge) begin
          shift_next   = {ps2_dat_s, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            rx_state_next = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall_edge) begin
          parity_next   = ps2_dat_s;
          rx_state_next = STOP;
        end
      end
      STOP: begin
        if (fall_edge) begin
          rx_state_next = IDLE;
          if ((^{shift_reg, parity_reg}) && ps2_dat_s) begin
            accept_byte = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
        end
      end
      default: rx_state_next = IDLE;
    endcase

    if (rx_state_reg != IDLE && !fall_edge && to_cnt_reg == TO_MAX) begin
      rx_state_next  = IDLE;
      frame_err_next = 1'b1;
    end

    if (accept_byte) begin
      scan_code_next  = shift_reg;
      scan_valid_next = 1'b1;
      dec_state_next  = NORMAL;
      case (dec_state_reg)
        NORMAL: begin
          if (shift_reg == 8'hF0) begin
            dec_state_next = BRK;
          end else if (shift_reg == 8'hE0) begin
            dec_state_next = EXT;
          end else if (map_res[8]) begin
            keycode_next = map_res[7:0];
          end
        end
        BRK: begin
          // Releasing an older key must not clear a newer held key
          if (map_res[8] && map_res[7:0] == keycode_reg) begin
            keycode_next = 8'h00;
          end
        end
        EXT: begin
          if (shift_reg == 8'hF0) begin
            dec_state_next = EXT_BRK;
          end
        end
        default: dec_state_next = NORMAL;
      endcase
    end else if (frame_err_next) begin
      dec_state_next = NORMAL;
    end
  end

  assign keycode    = keycode_reg;
  assign Scan_Code  = scan_code_reg;
  assign Scan_Valid = scan_valid_reg;
  assign Frame_Err  = frame_err_reg;

endmodule
